ioctl_ddr_packer: RTL and testbench
===================================

# ioctl_ddr_packer

Upstream loader stage for the DDR background display path. It accepts 16-bit `ioctl` words from `hps_io` during a file download and packs them into 64-bit little-endian DDR3 words. It writes those words directly on the `DDRAM_*` write port, throttling the HPS with `ioctl_wait`. When the download completes it flushes any partial word and raises `img_loaded`, which the line fetcher uses as its display-enable.

## Interface
Parameters:
- `BASE_ADDR`, default 29'h0300_0000: DDR 64-bit word address of image byte 0.
- `INDEX`, default 8'd1: `ioctl_index` value this block responds to.

Ports:
- `clk_sys` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `ioctl_download` in 1: download active.
- `ioctl_index` in 8: download target.
- `ioctl_wr` in 1: one-cycle strobe, data valid.
- `ioctl_addr` in 27: byte address; bit 0 is always 0.
- `ioctl_dout` in 16: data word.
- `ioctl_wait` out 1: HPS hold.
- `DDRAM_BUSY` in 1: controller wait-request.
- `DDRAM_WE` out 1: write request.
- `DDRAM_ADDR` out 29: word address.
- `DDRAM_DIN` out 64: write data.
- `DDRAM_BE` out 8: byte enables.
- `DDRAM_BURSTCNT` out 8: constant 8'd1.
- `DDRAM_RD` out 1: constant 0.
- `img_loaded` out 1: image present, level.
- `words_written` out 24: count of accepted DDR writes in the current download.

## Operation
- `act = ioctl_download & (ioctl_index == INDEX)`. Strobes with `act = 0` are ignored.
- Rising edge of `act`:
  - clear the buffer, `BE_acc`, and `words_written`;
  - `img_loaded <= 0`.
- Field mapping for each strobe:
  - lane `l = ioctl_addr[2:1]`;
  - word address `w = ioctl_addr[26:3]`;
  - data goes to `buf[16l+15:16l]`;
  - `BE_acc[2l+1:2l] <= 2'b11`.
- States:
  - **IDLE**:
    - buffer empty;
    - a strobe loads its lane and sets `cur_w = w`;
    - if `l == 3`, go to WRITE; otherwise go to FILL.
  - **FILL**:
    - strobe with `w == cur_w`: merge the lane; if `l == 3`, go to WRITE.
    - strobe with `w != cur_w`: latch data, `l`, and `w` into the pending register; go to WRITE.
    - `act` falls: go to WRITE with `final = 1`.
  - **WRITE**:
    - drive `DDRAM_WE = 1`, `DDRAM_ADDR = BASE_ADDR + cur_w`, `DDRAM_DIN = buf`, `DDRAM_BE = BE_acc`;
    - the write is accepted on the first cycle with `WE & ~BUSY`;
    - on acceptance: `words_written` +1, clear the buffer;
    - next state: if pending is valid, load it into the buffer and go to FILL (or back to WRITE if pending `l == 3`); else if `final`, go to DONE; else go to IDLE.
  - **DONE**:
    - `img_loaded <= 1`;
    - return to IDLE.
- `act` falling while in IDLE (buffer empty): go straight to DONE.
- `ioctl_wait`:
  - set on the cycle after any strobe that causes entry to WRITE;
  - cleared on the cycle after the write is accepted, provided no pending data remains to be written.
- A strobe arriving while in WRITE is a protocol violation. The HPS honours `ioctl_wait`, so the bench flags it as an error.
- Byte enables: lanes never written stay 0 in `DDRAM_BE`; bytes outside them are not modified in DDR.
- Address arithmetic is 29-bit and wraps modulo 2^29. `words_written` wraps at 2^24.

## Timing
- Reset values:
  - `DDRAM_WE`, `ioctl_wait`, `img_loaded`: 0;
  - `DDRAM_ADDR`, `DDRAM_DIN`, `DDRAM_BE`, `words_written`: 0;
  - state: IDLE.
- Asserting `reset` mid-write drops `DDRAM_WE` immediately, without waiting for the clock.
- Write issue: lane-3 strobe at cycle N gives `DDRAM_WE = 1` at N+1.
- Busy stall: while `BUSY` is high, `ADDR`, `DIN` and `BE` are held stable.
- Wait release: write accepted at cycle M gives `ioctl_wait = 0` at M+1.
- Throughput: one strobe every 2 cycles sustained when `BUSY` stays low.
- Completion: `act` falling at cycle F, with a partial word buffered and `BUSY` low, gives `WE` at F+1 and `img_loaded = 1` at F+3.
- Simultaneous events:
  - `act` rising together with a strobe: the clear happens first, then the strobe is captured.
  - `act` falling in the same cycle as a strobe: the strobe is merged first, then the final flush runs.

## Test plan
1. **Full word:** strobes at addr 0/2/4/6 with data 1111/2222/3333/4444 -> exactly one `WE`, `ADDR = BASE_ADDR`, `DIN = 64'h4444_3333_2222_1111`, `BE = 8'hFF`, `words_written = 1`.
2. **Partial final word:** strobes at addr 8/A/C, then `act` drops -> one write at `BASE_ADDR + 1` with `BE = 8'h3F`; `img_loaded` rises 2 cycles after acceptance.
3. **Busy stall:** hold `BUSY` high for 5 cycles during WRITE -> `WE` and `ioctl_wait` stay high and `DIN` stays stable for 6 cycles; exactly one write is accepted.
4. **Address jump:** strobe at addr 0 (data AAAA), then addr 0x100 (data BBBB), then end -> write at `BASE_ADDR` with `BE = 8'h03`, then write at `BASE_ADDR + 0x20` with `BE = 8'h03`, `DIN[15:0] = BBBB`.
5. **Wrong index:** `ioctl_index = 2` with 16 strobes -> no `WE`, `ioctl_wait` stays 0, `img_loaded` unchanged.
6. **Reset mid-write:** assert `reset` while `WE = 1` and `BUSY = 1` -> all outputs are 0 in the same cycle; a following clean download of 4 words produces correct data.

Source files
------------

// File: rtl/ioctl_ddr_packer_if.sv
// HPS ioctl download port, DDR3 write port and loader status, bundled for the packer.
// "master" is the HPS/controller side; "slave" is the packer.
interface ioctl_ddr_packer_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        DDRAM_BUSY;
  logic        DDRAM_WE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic [7:0]  DDRAM_BURSTCNT;
  logic        DDRAM_RD;
  logic        img_loaded;
  logic [23:0] words_written;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, DDRAM_BUSY,
    input  ioctl_wait, DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_BURSTCNT,
           DDRAM_RD, img_loaded, words_written
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, DDRAM_BUSY,
    output ioctl_wait, DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_BURSTCNT,
           DDRAM_RD, img_loaded, words_written
  );
endinterface

// File: rtl/ioctl_ddr_packer.sv
// Packs 16-bit ioctl download words into 64-bit DDR writes; lane-3 strobe -> WE next cycle.
// DDRAM_BUSY stalls the write with outputs held; ioctl_wait holds the HPS until it is accepted.
module ioctl_ddr_packer #(
  parameter logic [28:0] BASE_ADDR = 29'h0300_0000,
  parameter logic [7:0]  INDEX     = 8'd1
) (
  input logic               clk_sys,
  input logic               reset,
  ioctl_ddr_packer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t      state, state_nxt, state_eff;
  logic        act, act_q, act_rise, act_fall, stb, fin, accept;
  logic [1:0]  lane;
  logic [23:0] waddr;
  logic [63:0] data_q, data_nxt;
  logic [7:0]  be_q, be_nxt;
  logic [23:0] cur_w, cur_w_nxt;
  logic        pend_vld;
  logic [15:0] pend_dat;
  logic [1:0]  pend_l;
  logic [23:0] pend_w;
  logic        to_pend, pop_pend, do_merge;
  logic [1:0]  m_lane;
  logic [15:0] m_dat;
  logic        fin_q, wait_q, wait_nxt, loaded_q;
  logic [23:0] words_q;
  logic        addr_unused;

  assign act      = bus.ioctl_download & (bus.ioctl_index == INDEX);
  assign act_rise = act & ~act_q;
  assign act_fall = ~act & act_q;
  // A strobe in the cycle act drops still belongs to this download and is merged before the flush.
  assign stb      = bus.ioctl_wr & (act | act_fall);
  assign lane     = bus.ioctl_addr[2:1];
  assign waddr    = bus.ioctl_addr[26:3];
  assign addr_unused = bus.ioctl_addr[0];
  assign fin      = (fin_q & ~act_rise) | act_fall;
  assign accept   = (state == S_WRITE) & ~bus.DDRAM_BUSY;
  assign state_eff = act_rise ? S_IDLE : state;

  always_comb begin
    state_nxt = state_eff;
    wait_nxt  = wait_q & ~act_rise;
    data_nxt  = (act_rise | accept) ? 64'd0 : data_q;
    be_nxt    = (act_rise | accept) ? 8'd0 : be_q;
    cur_w_nxt = cur_w;
    to_pend   = 1'b0;
    pop_pend  = 1'b0;
    do_merge  = 1'b0;
    m_lane    = lane;
    m_dat     = bus.ioctl_dout;
    case (state_eff)
      S_IDLE: begin
        if (stb) begin
          do_merge  = 1'b1;
          cur_w_nxt = waddr;
          state_nxt = (lane == 2'd3 || fin) ? S_WRITE : S_FILL;
        end else if (fin) begin
          state_nxt = S_DONE;
        end
      end
      S_FILL: begin
        if (stb && waddr == cur_w) begin
          do_merge = 1'b1;
          if (lane == 2'd3 || fin) state_nxt = S_WRITE;
        end else if (stb) begin
          to_pend   = 1'b1;
          state_nxt = S_WRITE;
        end else if (fin) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (pend_vld) begin
            pop_pend  = 1'b1;
            do_merge  = 1'b1;
            m_lane    = pend_l;
            m_dat     = pend_dat;
            cur_w_nxt = pend_w;
            state_nxt = (pend_l == 2'd3) ? S_WRITE : S_FILL;
          end else begin
            state_nxt = fin ? S_DONE : S_IDLE;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
    endcase
    if (do_merge) begin
      data_nxt[{m_lane, 4'd0} +: 16] = m_dat;
      be_nxt[{m_lane, 1'b0} +: 2]    = 2'b11;
    end
    if (stb && state_eff != S_WRITE && state_nxt == S_WRITE)
      wait_nxt = 1'b1;
    else if (accept && state_nxt != S_WRITE)
      wait_nxt = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      act_q    <= 1'b0;
      data_q   <= 64'd0;
      be_q     <= 8'd0;
      cur_w    <= 24'd0;
      pend_vld <= 1'b0;
      pend_dat <= 16'd0;
      pend_l   <= 2'd0;
      pend_w   <= 24'd0;
      fin_q    <= 1'b0;
      wait_q   <= 1'b0;
      loaded_q <= 1'b0;
      words_q  <= 24'd0;
    end else begin
      state  <= state_nxt;
      act_q  <= act;
      data_q <= data_nxt;
      be_q   <= be_nxt;
      cur_w  <= cur_w_nxt;
      wait_q <= wait_nxt;
      if (act_rise || pop_pend) pend_vld <= 1'b0;
      else if (to_pend)         pend_vld <= 1'b1;
      if (to_pend) begin
        pend_dat <= bus.ioctl_dout;
        pend_l   <= lane;
        pend_w   <= waddr;
      end
      if (act_rise)             fin_q <= 1'b0;
      else if (act_fall)        fin_q <= 1'b1;
      else if (state == S_DONE) fin_q <= 1'b0;
      if (act_rise)             loaded_q <= 1'b0;
      else if (state == S_DONE) loaded_q <= 1'b1;
      if (act_rise)    words_q <= 24'd0;
      else if (accept) words_q <= words_q + 24'd1;
    end
  end

  // Write-port outputs are gated by WE so they read zero outside a write, including under reset.
  assign bus.DDRAM_WE       = (state == S_WRITE);
  assign bus.DDRAM_ADDR     = bus.DDRAM_WE ? (BASE_ADDR + {5'd0, cur_w}) : 29'd0;
  assign bus.DDRAM_DIN      = bus.DDRAM_WE ? data_q : 64'd0;
  assign bus.DDRAM_BE       = bus.DDRAM_WE ? be_q : 8'd0;
  assign bus.DDRAM_BURSTCNT = 8'd1;
  assign bus.DDRAM_RD       = 1'b0;
  assign bus.ioctl_wait     = wait_q;
  assign bus.img_loaded     = loaded_q;
  assign bus.words_written  = words_q;
endmodule

// File: tb/tb_ioctl_ddr_packer.sv
// Bench for ioctl_ddr_packer: table vectors, hand-timed corner sequences, and randomized downloads.
module tb_ioctl_ddr_packer;
  localparam logic [28:0] BASE = 29'h0300_0000;

  typedef struct packed {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } wr_t;

  typedef struct packed {
    logic [2:0]        n;
    logic [3:0][26:0]  a;
    logic [3:0][15:0]  d;
    logic [28:0]       ea;
    logic [63:0]       ed;
    logic [7:0]        ebe;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ioctl_ddr_packer_if bus();
  ioctl_ddr_packer #(.BASE_ADDR(BASE), .INDEX(8'd1)) dut (.clk_sys(clk), .reset(rst), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  int   we_cycles = 0;
  logic rand_busy = 1'b0;
  wr_t  got_q[$];
  wr_t  exp_q[$];
  logic [26:0] s_addr[$];
  logic [15:0] s_dat[$];

  always @(negedge clk) begin : monitor
    wr_t w;
    if (!rst && bus.DDRAM_WE) begin
      we_cycles++;
      if (!bus.DDRAM_BUSY) begin
        w.a = bus.DDRAM_ADDR; w.d = bus.DDRAM_DIN; w.be = bus.DDRAM_BE;
        got_q.push_back(w);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_busy) bus.DDRAM_BUSY = ($urandom_range(0, 3) == 0);
  endtask

  task automatic strobe(input logic [26:0] a, input logic [15:0] d);
    int n;
    n = 0;
    while (bus.ioctl_wait && n < 200) begin cyc(); n++; end
    chk("wait_release", 64'(bus.ioctl_wait), 64'd0);
    chk("no_strobe_in_write", 64'(bus.DDRAM_WE), 64'd0);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = a; bus.ioctl_dout = d;
    cyc();
    bus.ioctl_wr = 1'b0;
  endtask

  function automatic wr_t mk(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_t r;
    r.a = a; r.d = d; r.be = be;
    return r;
  endfunction

  // Reference: consecutive strobes to one 64-bit word form one write; a word closes
  // when lane 3 is written, when the word address changes, or when the download ends.
  task automatic build_exp();
    logic        open;
    logic [23:0] cw;
    logic [63:0] d;
    logic [7:0]  be;
    open = 1'b0; cw = '0; d = '0; be = '0;
    exp_q.delete();
    for (int i = 0; i < s_addr.size(); i++) begin
      logic [26:0] a;
      int          l;
      a = s_addr[i];
      l = int'(a[2:1]);
      if (open && a[26:3] != cw) begin
        exp_q.push_back(mk(BASE + {5'd0, cw}, d, be));
        open = 1'b0;
      end
      if (!open) begin open = 1'b1; cw = a[26:3]; d = '0; be = '0; end
      d[16*l +: 16] = s_dat[i];
      be[2*l +: 2]  = 2'b11;
      if (l == 3) begin
        exp_q.push_back(mk(BASE + {5'd0, cw}, d, be));
        open = 1'b0;
      end
    end
    if (open) exp_q.push_back(mk(BASE + {5'd0, cw}, d, be));
  endtask

  task automatic run_dl(input string tag, input int max_gap);
    int base;
    int n;
    base = got_q.size();
    bus.ioctl_index = 8'd1;
    bus.ioctl_download = 1'b1;
    cyc();
    for (int i = 0; i < s_addr.size(); i++) begin
      strobe(s_addr[i], s_dat[i]);
      repeat ($urandom_range(0, max_gap)) cyc();
    end
    bus.ioctl_download = 1'b0;
    n = 0;
    while (!bus.img_loaded && n < 500) begin cyc(); n++; end
    chk({tag, "_img_loaded"}, 64'(bus.img_loaded), 64'd1);
    chk({tag, "_nwrites"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(got_q[base+i].a), 64'(exp_q[i].a));
        chk($sformatf("%s_din%0d", tag, i), got_q[base+i].d, exp_q[i].d);
        chk($sformatf("%s_be%0d", tag, i), 64'(got_q[base+i].be), 64'(exp_q[i].be));
      end
    end
    chk({tag, "_words_written"}, 64'(bus.words_written), 64'(exp_q.size() % (1 << 24)));
  endtask

  initial begin : main
    vec_t        vt[5];
    int          base;
    logic [63:0] din0;
    logic        wait_seen;
    logic [26:0] a;

    vt[0] = '{3'd4, {27'h6, 27'h4, 27'h2, 27'h0}, {16'h4444, 16'h3333, 16'h2222, 16'h1111},
              BASE, 64'h4444_3333_2222_1111, 8'hFF};
    vt[1] = '{3'd3, {27'h0, 27'hC, 27'hA, 27'h8}, {16'h0, 16'h7777, 16'h6666, 16'h5555},
              BASE + 29'd1, 64'h0000_7777_6666_5555, 8'h3F};
    vt[2] = '{3'd1, {27'h0, 27'h0, 27'h0, 27'h12}, {16'h0, 16'h0, 16'h0, 16'h9ABC},
              BASE + 29'd2, 64'h0000_0000_9ABC_0000, 8'h0C};
    vt[3] = '{3'd2, {27'h0, 27'h0, 27'h82, 27'h84}, {16'h0, 16'h0, 16'hDDDD, 16'hCCCC},
              BASE + 29'h10, 64'h0000_CCCC_DDDD_0000, 8'h3C};
    vt[4] = '{3'd2, {27'h0, 27'h0, 27'h7FF_FFFE, 27'h7FF_FFFC}, {16'h0, 16'h0, 16'h5678, 16'h1234},
              29'h03FF_FFFF, 64'h5678_1234_0000_0000, 8'hF0};

    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0; bus.DDRAM_BUSY = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    chk("reset_we", 64'(bus.DDRAM_WE), 64'd0);
    chk("reset_wait", 64'(bus.ioctl_wait), 64'd0);
    chk("reset_loaded", 64'(bus.img_loaded), 64'd0);
    chk("reset_addr", 64'(bus.DDRAM_ADDR), 64'd0);
    chk("reset_din", bus.DDRAM_DIN, 64'd0);
    chk("reset_be", 64'(bus.DDRAM_BE), 64'd0);
    chk("reset_words", 64'(bus.words_written), 64'd0);
    chk("burstcnt", 64'(bus.DDRAM_BURSTCNT), 64'd1);
    chk("rd", 64'(bus.DDRAM_RD), 64'd0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 5; i++) begin
      s_addr.delete(); s_dat.delete(); exp_q.delete();
      for (int j = 0; j < int'(vt[i].n); j++) begin
        s_addr.push_back(vt[i].a[j]);
        s_dat.push_back(vt[i].d[j]);
      end
      exp_q.push_back(mk(vt[i].ea, vt[i].ed, vt[i].ebe));
      run_dl($sformatf("vec%0d", i), 0);
    end

    // Write issue one cycle after the lane-3 strobe, wait released one cycle after acceptance.
    bus.ioctl_index = 8'd1; bus.ioctl_download = 1'b1; cyc();
    strobe(27'h0, 16'h1111); strobe(27'h2, 16'h2222); strobe(27'h4, 16'h3333);
    strobe(27'h6, 16'h4444);
    chk("issue_we", 64'(bus.DDRAM_WE), 64'd1);
    chk("issue_wait", 64'(bus.ioctl_wait), 64'd1);
    cyc();
    chk("release_wait", 64'(bus.ioctl_wait), 64'd0);
    chk("release_words", 64'(bus.words_written), 64'd1);
    bus.ioctl_download = 1'b0;
    repeat (3) cyc();

    // Partial word flush on act falling: WE at F+1, img_loaded at F+3.
    bus.ioctl_download = 1'b1; cyc();
    strobe(27'h8, 16'h5555); strobe(27'hA, 16'h6666); strobe(27'hC, 16'h7777);
    bus.ioctl_download = 1'b0;
    cyc();
    chk("flush_we", 64'(bus.DDRAM_WE), 64'd1);
    chk("flush_addr", 64'(bus.DDRAM_ADDR), 64'(BASE + 29'd1));
    chk("flush_be", 64'(bus.DDRAM_BE), 64'h3F);
    cyc();
    chk("flush_we_done", 64'(bus.DDRAM_WE), 64'd0);
    chk("flush_loaded_early", 64'(bus.img_loaded), 64'd0);
    cyc();
    chk("flush_loaded", 64'(bus.img_loaded), 64'd1);

    // Busy stall for 5 cycles: request and data held for 6 cycles, one acceptance.
    bus.ioctl_download = 1'b1; cyc();
    bus.DDRAM_BUSY = 1'b1;
    strobe(27'h0, 16'hA1A1); strobe(27'h2, 16'hB2B2); strobe(27'h4, 16'hC3C3);
    base = got_q.size();
    strobe(27'h6, 16'hD4D4);
    din0 = 64'hD4D4_C3C3_B2B2_A1A1;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) cyc();
      if (k == 6) bus.DDRAM_BUSY = 1'b0;
      chk($sformatf("stall_we%0d", k), 64'(bus.DDRAM_WE), 64'd1);
      chk($sformatf("stall_wait%0d", k), 64'(bus.ioctl_wait), 64'd1);
      chk($sformatf("stall_din%0d", k), bus.DDRAM_DIN, din0);
    end
    cyc();
    chk("stall_one_write", 64'(got_q.size() - base), 64'd1);
    chk("stall_we_after", 64'(bus.DDRAM_WE), 64'd0);
    bus.ioctl_download = 1'b0;
    repeat (3) cyc();

    // Address jump closes the open word and starts a new one.
    s_addr = '{27'h0, 27'h100}; s_dat = '{16'hAAAA, 16'hBBBB};
    exp_q.delete();
    exp_q.push_back(mk(BASE, 64'h0000_0000_0000_AAAA, 8'h03));
    exp_q.push_back(mk(BASE + 29'h20, 64'h0000_0000_0000_BBBB, 8'h03));
    run_dl("jump", 0);

    // Strobes for another index are ignored entirely.
    base = we_cycles;
    wait_seen = 1'b0;
    bus.ioctl_index = 8'd2; bus.ioctl_download = 1'b1; cyc();
    for (int i = 0; i < 16; i++) begin
      strobe(27'(2 * i), 16'(i));
      wait_seen |= bus.ioctl_wait;
    end
    bus.ioctl_download = 1'b0;
    repeat (4) cyc();
    chk("wrong_idx_no_we", 64'(we_cycles - base), 64'd0);
    chk("wrong_idx_no_wait", 64'(wait_seen), 64'd0);
    chk("wrong_idx_loaded", 64'(bus.img_loaded), 64'd1);

    // Asynchronous reset while a write is stalled.
    bus.ioctl_index = 8'd1; bus.ioctl_download = 1'b1; bus.DDRAM_BUSY = 1'b1; cyc();
    strobe(27'h6, 16'hFACE);
    chk("rst_pre_we", 64'(bus.DDRAM_WE), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_we", 64'(bus.DDRAM_WE), 64'd0);
    chk("rst_async_wait", 64'(bus.ioctl_wait), 64'd0);
    chk("rst_async_addr", 64'(bus.DDRAM_ADDR), 64'd0);
    chk("rst_async_din", bus.DDRAM_DIN, 64'd0);
    chk("rst_async_be", 64'(bus.DDRAM_BE), 64'd0);
    chk("rst_async_loaded", 64'(bus.img_loaded), 64'd0);
    chk("rst_async_words", 64'(bus.words_written), 64'd0);
    bus.ioctl_download = 1'b0; bus.DDRAM_BUSY = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    s_addr.delete(); s_dat.delete();
    for (int i = 0; i < 16; i++) begin
      s_addr.push_back(27'(2 * i));
      s_dat.push_back(16'($urandom));
    end
    build_exp();
    run_dl("post_reset", 0);

    // Randomized downloads with random BUSY and gaps.
    rand_busy = 1'b1;
    for (int t = 0; t < 20; t++) begin
      s_addr.delete(); s_dat.delete();
      a = 27'($urandom_range(0, 63) * 2);
      for (int i = 0; i < int'($urandom_range(0, 24)); i++) begin
        s_addr.push_back(a);
        s_dat.push_back(16'($urandom));
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: a = a + 27'd2;
          6, 7:             a = {a[26:3], 2'($urandom_range(0, 3)), 1'b0};
          default:          a = 27'($urandom_range(0, 4095) * 2);
        endcase
      end
      build_exp();
      run_dl($sformatf("rnd%0d", t), 2);
    end
    rand_busy = 1'b0;
    bus.DDRAM_BUSY = 1'b0;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
